// File: rtl/bus_copy_master.sv
// -----------------------------------------------------------------------------
// bus_copy_master
//
// Purpose:
//   Bus initiator that copies a block of 32-bit words from a source byte
//   address to a destination byte address over the CPU-style memory bus
//   (valid / addr / wstrb / wdata / rdata / ready / error). It sits beside the
//   CPU behind a two-master arbiter and lets software drain peripheral FIFOs
//   into RAM without a CPU load/store loop. Each word is moved as one read
//   followed by one write. With a zero-wait responder, that costs two cycles
//   per word.
//
// Parameters:
//   COUNT_WIDTH     width of the word-count field (max 2^COUNT_WIDTH-1 words)
//   TIMEOUT_CYCLES  cycles an access may stall without ready/error before it
//                   is treated as a bus error
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_src/dst       source / destination byte addresses (word aligned)
//   cmd_words         number of words to copy (0 = no-op)
//   busy              transfer in progress (accept edge through FINISH)
//   done              one-cycle pulse at transfer end, success or error
//   err, err_addr     sticky error flag and faulting address, cleared on the
//                     next accepted command
//   m_valid ... m_wdata   master side of the memory bus
//   m_rdata, m_ready, m_error   responder side of the memory bus
// -----------------------------------------------------------------------------
module bus_copy_master #(
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  // command / status
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_src,
  input  logic [31:0]            cmd_dst,
  input  logic [COUNT_WIDTH-1:0] cmd_words,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            err_addr,
  // memory bus, master side
  output logic                   m_valid,
  output logic [31:0]            m_addr,
  output logic [3:0]             m_wstrb,
  output logic [31:0]            m_wdata,
  input  logic [31:0]            m_rdata,
  input  logic                   m_ready,
  input  logic                   m_error
);

  // Timeout counter must hold values up to TIMEOUT_CYCLES-1.
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                 state_q, state_d;

  // Working copies of the command: advanced by one word after each write.
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  // Bus request registers. They change only on a handshake edge (or on
  // entry/exit), so address, strobe and data stay stable across wait states.
  logic                   valid_q, valid_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [31:0]            wdata_q, wdata_d;   // doubles as the read-data latch

  logic                   err_q, err_d;
  logic [31:0]            err_addr_q, err_addr_d;

  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic                   stall;
  logic                   tmo_hit;
  logic                   bus_fault;

  // A stalled access counts toward the timeout. Hitting the limit is handled
  // exactly like a responder error.
  assign stall     = valid_q && !m_ready && !m_error;
  assign tmo_hit   = stall && (tmo_q == TMO_LAST);
  assign bus_fault = valid_q && (m_error || tmo_hit);

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    tmo_d      = tmo_q;

    if (stall) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d      = cmd_src;
          dst_d      = cmd_dst;
          cnt_d      = cmd_words;
          err_d      = 1'b0;
          err_addr_d = 32'h0;
          if (cmd_words == '0) begin
            state_d = S_FINISH;
          end else if (cmd_src[1:0] != 2'b00) begin
            // Source is reported before destination when both are bad.
            err_d      = 1'b1;
            err_addr_d = cmd_src;
            state_d    = S_FINISH;
          end else if (cmd_dst[1:0] != 2'b00) begin
            err_d      = 1'b1;
            err_addr_d = cmd_dst;
            state_d    = S_FINISH;
          end else begin
            // Request the first read right away so it appears the cycle
            // after the accept edge.
            valid_d = 1'b1;
            addr_d  = cmd_src;
            wstrb_d = 4'h0;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (bus_fault) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          valid_d    = 1'b0;
          wstrb_d    = 4'h0;
          state_d    = S_FINISH;
        end else if (m_ready) begin
          // Keep m_valid high and turn the read straight into the write.
          wdata_d = m_rdata;
          addr_d  = dst_q;
          wstrb_d = 4'hF;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (bus_fault) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          valid_d    = 1'b0;
          wstrb_d    = 4'h0;
          state_d    = S_FINISH;
        end else if (m_ready) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - COUNT_WIDTH'(1);
          if (cnt_q == COUNT_WIDTH'(1)) begin
            valid_d = 1'b0;
            wstrb_d = 4'h0;
            state_d = S_FINISH;
          end else begin
            addr_d  = src_q + 32'd4;
            wstrb_d = 4'h0;
            state_d = S_READ;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Every state entry restarts the timeout window.
    if (state_d != state_q) begin
      tmo_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= 32'h0;
      dst_q      <= 32'h0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      addr_q     <= 32'h0;
      wstrb_q    <= 4'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign m_valid   = valid_q;
  assign m_addr    = addr_q;
  assign m_wstrb   = wstrb_q;
  assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_copy_master.sv
module tb_bus_copy_master;

  localparam int CW  = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_src = 32'h0;
  logic [31:0]   cmd_dst = 32'h0;
  logic [CW-1:0] cmd_words = '0;
  logic          busy, done, err;
  logic [31:0]   err_addr;
  logic          m_valid;
  logic [31:0]   m_addr;
  logic [3:0]    m_wstrb;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = 32'h0;
  logic          m_ready = 1'b0;
  logic          m_error = 1'b0;

  always #5 clk = ~clk;

  bus_copy_master #(
    .COUNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_words(cmd_words),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .m_valid(m_valid), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
  } stat_t;

  bus_t  bus_q[$];
  stat_t stat_q[$];
  bus_t  be;
  stat_t se;

  logic [31:0] mem [bit [31:0]];

  int checks = 0;
  int errors = 0;

  // responder controls
  int          wait_n = 0;
  bit          hang   = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_at = 32'h0;

  int wcnt = 0, comp_cnt = 0, write_cnt = 0;
  int valid_cyc = 0, busy_cyc = 0, done_cnt = 0;

  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
  logic [3:0]  prev_wstrb = 4'h0;
  int          prev_comp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD00000 ^ a;
  endfunction

  // Responder: decides ready/error/rdata mid-cycle from the registered request.
  initial forever begin
    @(negedge clk);
    m_ready = 1'b0;
    m_error = 1'b0;
    m_rdata = 32'h0;
    if (m_valid) begin
      if (err_en && m_addr == err_at && m_wstrb == 4'h0) begin
        m_error = 1'b1;
      end else if (!hang && wcnt >= wait_n) begin
        m_ready = 1'b1;
        if (m_wstrb == 4'h0) m_rdata = rd(m_addr);
      end
    end
  end

  // Bus monitor: every completed access is popped from the scoreboard.
  initial forever begin
    @(posedge clk);
    if (m_valid && (m_ready || m_error)) begin
      comp_cnt++;
      wcnt = 0;
      if (m_ready && !m_error && m_wstrb == 4'hF) begin
        mem[m_addr] = m_wdata;
        write_cnt++;
      end
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got addr %h wstrb %h, expected no access", m_addr, m_wstrb);
      end else begin
        be = bus_q.pop_front();
        chk("bus_addr", m_addr, be.addr);
        chk("bus_wstrb", {28'h0, m_wstrb}, {28'h0, be.wstrb});
        if (be.wstrb == 4'hF) chk("bus_wdata", m_wdata, be.wdata);
      end
    end else if (m_valid) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Status / stability monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (m_valid) valid_cyc++;
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      if (stat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1, expected no completion");
      end else begin
        se = stat_q.pop_front();
        chk("done_err", 32'(err), 32'(se.err));
        if (se.err) chk("done_err_addr", err_addr, se.addr);
      end
    end
    if (m_valid && prev_valid && comp_cnt == prev_comp) begin
      chk("stall_addr_stable", m_addr, prev_addr);
      chk("stall_wstrb_stable", {28'h0, m_wstrb}, {28'h0, prev_wstrb});
      chk("stall_wdata_stable", m_wdata, prev_wdata);
    end
    prev_valid = m_valid;
    prev_addr  = m_addr;
    prev_wstrb = m_wstrb;
    prev_wdata = m_wdata;
    prev_comp  = comp_cnt;
  end

  task automatic push_rd(input logic [31:0] a);
    bus_q.push_back('{addr: a, wstrb: 4'h0, wdata: 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    bus_q.push_back('{addr: a, wstrb: 4'hF, wdata: d});
  endtask

  task automatic push_stat(input logic e, input logic [31:0] a);
    stat_q.push_back('{err: e, addr: a});
  endtask

  task automatic clear_counts();
    valid_cyc = 0;
    busy_cyc  = 0;
    done_cnt  = 0;
    write_cnt = 0;
  endtask

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [CW-1:0] n);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_words = n;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, expected a done pulse", name, budget);
    end
    @(negedge clk);
    chk("after_done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("after_done_busy", 32'(busy), 32'd0);
    chk("after_done_done_low", 32'(done), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] eaddr;
  } mis_t;

  mis_t mis_tab [3];

  initial begin
    for (int k = 0; k < 4; k++) mem[32'h30000000 + 32'(4 * k)] = 32'h11 * 32'(k + 1);
    mem[32'h70000000] = 32'hA5A5A5A5;
    mem[32'h70000004] = 32'h5A5A5A5A;
    for (int k = 0; k < 10; k++) mem[32'h40000000 + 32'(4 * k)] = 32'h1000 + 32'(k);

    // reset state, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wstrb", {28'h0, m_wstrb}, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 4-word copy, zero-wait responder
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      push_rd(32'h30000000 + 32'(4 * k));
      push_wr(32'h30000100 + 32'(4 * k), 32'h11 * 32'(k + 1));
    end
    push_stat(1'b0, 32'h0);
    issue(32'h30000000, 32'h30000100, 16'd4);
    wait_done(100, "zero_wait");
    chk("zw_valid_cycles", 32'(valid_cyc), 32'd8);
    chk("zw_busy_cycles", 32'(busy_cyc), 32'd9);
    chk("zw_done_count", 32'(done_cnt), 32'd1);
    chk("zw_writes", 32'(write_cnt), 32'd4);
    chk("zw_err", 32'(err), 32'd0);
    chk("zw_mem0", rd(32'h30000100), 32'h11);
    chk("zw_mem1", rd(32'h30000104), 32'h22);
    chk("zw_mem2", rd(32'h30000108), 32'h33);
    chk("zw_mem3", rd(32'h3000010C), 32'h44);
    chk("zw_bus_left", 32'(bus_q.size()), 32'd0);

    // same copy with 3 wait cycles per access
    clear_counts();
    wait_n = 3;
    for (int k = 0; k < 4; k++) begin
      push_rd(32'h30000000 + 32'(4 * k));
      push_wr(32'h30000200 + 32'(4 * k), 32'h11 * 32'(k + 1));
    end
    push_stat(1'b0, 32'h0);
    issue(32'h30000000, 32'h30000200, 16'd4);
    wait_done(200, "wait3");
    wait_n = 0;
    chk("ws_valid_cycles", 32'(valid_cyc), 32'd32);
    chk("ws_done_count", 32'(done_cnt), 32'd1);
    chk("ws_err", 32'(err), 32'd0);
    chk("ws_mem0", rd(32'h30000200), 32'h11);
    chk("ws_mem3", rd(32'h3000020C), 32'h44);
    chk("ws_bus_left", 32'(bus_q.size()), 32'd0);

    // bus error on the second read
    clear_counts();
    err_en = 1'b1;
    err_at = 32'h70000004;
    push_rd(32'h70000000);
    push_wr(32'h70000100, 32'hA5A5A5A5);
    push_rd(32'h70000004);
    push_stat(1'b1, 32'h70000004);
    issue(32'h70000000, 32'h70000100, 16'd3);
    wait_done(100, "bus_error");
    err_en = 1'b0;
    chk("be_writes", 32'(write_cnt), 32'd1);
    chk("be_done_count", 32'(done_cnt), 32'd1);
    chk("be_mem0", rd(32'h70000100), 32'hA5A5A5A5);
    chk("be_bus_left", 32'(bus_q.size()), 32'd0);
    @(negedge clk);
    chk("be_err_sticky", 32'(err), 32'd1);
    chk("be_err_addr_sticky", err_addr, 32'h70000004);

    // misaligned addresses: no bus traffic, source reported first
    mis_tab[0] = '{src: 32'h00000002, dst: 32'h00000100, eaddr: 32'h00000002};
    mis_tab[1] = '{src: 32'h30000000, dst: 32'h30000401, eaddr: 32'h30000401};
    mis_tab[2] = '{src: 32'h00000003, dst: 32'h00000005, eaddr: 32'h00000003};
    for (int i = 0; i < 3; i++) begin
      clear_counts();
      push_stat(1'b1, mis_tab[i].eaddr);
      issue(mis_tab[i].src, mis_tab[i].dst, 16'd5);
      wait_done(20, "misaligned");
      chk("mis_valid_cycles", 32'(valid_cyc), 32'd0);
      chk("mis_done_count", 32'(done_cnt), 32'd1);
    end

    // zero-length command clears the error
    clear_counts();
    push_stat(1'b0, 32'h0);
    issue(32'h30000000, 32'h30000400, 16'd0);
    wait_done(20, "zero_words");
    chk("zero_valid_cycles", 32'(valid_cyc), 32'd0);
    chk("zero_done_count", 32'(done_cnt), 32'd1);
    chk("zero_err", 32'(err), 32'd0);

    // responder never answers: timeout after TMO valid cycles
    clear_counts();
    hang = 1'b1;
    push_stat(1'b1, 32'h50000000);
    issue(32'h50000000, 32'h50000100, 16'd1);
    wait_done(100, "timeout");
    hang = 1'b0;
    chk("tmo_valid_cycles", 32'(valid_cyc), 32'(TMO));
    chk("tmo_m_valid_low", 32'(m_valid), 32'd0);
    chk("tmo_done_count", 32'(done_cnt), 32'd1);
    chk("tmo_writes", 32'(write_cnt), 32'd0);

    // reset during the third write of a 10-word copy
    clear_counts();
    push_rd(32'h40000000);
    push_wr(32'h40000100, 32'h1000);
    push_rd(32'h40000004);
    push_wr(32'h40000104, 32'h1001);
    push_rd(32'h40000008);
    issue(32'h40000000, 32'h40000100, 16'd10);
    repeat (5) @(negedge clk);
    chk("mid_write_wstrb", {28'h0, m_wstrb}, 32'hF);
    chk("mid_write_addr", m_addr, 32'h40000108);
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_bus_left", 32'(bus_q.size()), 32'd0);
    chk("arst_writes", 32'(write_cnt), 32'd2);
    chk("arst_no_done", 32'(done_cnt), 32'd0);

    // a normal copy after the reset
    clear_counts();
    for (int k = 0; k < 2; k++) begin
      push_rd(32'h30000000 + 32'(4 * k));
      push_wr(32'h30000300 + 32'(4 * k), 32'h11 * 32'(k + 1));
    end
    push_stat(1'b0, 32'h0);
    issue(32'h30000000, 32'h30000300, 16'd2);
    wait_done(100, "post_reset");
    chk("pr_mem0", rd(32'h30000300), 32'h11);
    chk("pr_mem1", rd(32'h30000304), 32'h22);
    chk("pr_done_count", 32'(done_cnt), 32'd1);
    chk("pr_bus_left", 32'(bus_q.size()), 32'd0);
    chk("pr_stat_left", 32'(stat_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion by %0t, expected the run to end", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator: copies a block of 32-bit words from one address to another over the CPU-style memory bus.
- The bus uses valid, addr, wstrb, wdata, rdata, ready and error; this block drives it from the master side.
- Sits beside the CPU behind a two-master arbiter, so it can drain tactile/jtag devices into stack RAM without CPU load/store loops.
- Commands come from a local config register block; status returns to it.

Parameters:
- COUNT_WIDTH, 16, width of the word-count field; maximum transfer is 2^COUNT_WIDTH-1 words.
- TIMEOUT_CYCLES, 1024, cycles m_valid may stay high without ready/error before the block declares a timeout error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_src  in  32  source byte address
- cmd_dst  in  32  destination byte address
- cmd_words  in  COUNT_WIDTH  number of words to copy
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end (success or error)
- err  out  1  sticky error flag, cleared on next accepted command
- err_addr  out  32  address of the faulting access
- m_valid  out  1  bus request
- m_addr  out  32  bus address
- m_wstrb  out  4  0 = read, 4'hF = write
- m_wdata  out  32  write data
- m_rdata  in  32  read data
- m_ready  in  1  responder completes access
- m_error  in  1  responder rejects access / unmapped

Behaviour:
- Reset (async, immediate):
  - Outputs: m_valid=0, m_addr=0, m_wstrb=0, m_wdata=0, busy=0, done=0, err=0, err_addr=0, cmd_ready=1.
  - FSM goes to IDLE. An in-flight access is abandoned with no completion.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - Command is accepted on a cycle with cmd_valid && cmd_ready.
  - On accept: latch src, dst and count; clear err; raise busy.
  - If cmd_words==0 -> FINISH.
  - Else if src[1:0]!=0 or dst[1:0]!=0 -> set err, err_addr = the misaligned address (src checked first), go to FINISH. No bus access is issued.
  - Else -> READ.
- READ:
  - Drives m_valid=1, m_addr=src, m_wstrb=0.
  - Edge with m_ready=1: latch m_rdata into the data register; next state WRITE.
- WRITE:
  - Drives m_valid=1, m_addr=dst, m_wstrb=4'hF, m_wdata=latched word.
  - Edge with m_ready=1: src+=4, dst+=4, count-=1.
  - If count becomes 0 -> FINISH, else -> READ.
- m_valid stays high across READ<->WRITE transitions. Address, wstrb and wdata change only on the edge where ready was sampled.
- Throughput: 2 cycles per word with a zero-wait responder (ready combinational in the same cycle).
- Addresses wrap modulo 2^32. No bus-boundary checks are made.
- m_error has priority over m_ready when both are high:
  - Set err, err_addr = current m_addr.
  - Go to FINISH; the remaining words are not transferred.
- Timeout:
  - A counter resets on every state entry and counts while m_valid && !m_ready && !m_error.
  - Reaching TIMEOUT_CYCLES has the same effect as m_error.
- FINISH:
  - m_valid=0, done=1 for exactly one cycle, busy=0 on exit, then IDLE.
  - cmd_ready returns to 1 in the cycle after FINISH.
- Latency (zero-wait responder): command accepted at edge N -> first read valid in cycle N+1; done high one cycle after the final write's ready edge.
- cmd_* are ignored while busy.
- err and err_addr hold until the next accepted command.

Test Plan:
- src=0x30000000, dst=0x30000100, words=4, zero-wait RAM preloaded with 0x11..0x44 -> dst holds 0x11,0x22,0x33,0x44; 8 bus accesses alternating read/write; done pulses exactly once; err=0; busy high 9 cycles.
- Same copy with responder inserting 3 wait cycles per access -> m_addr/m_wdata stable during waits; data correct; no timeout.
- words=3, m_error asserted on the second read at 0x70000004 -> err=1, err_addr=0x70000004; only one write issued; done pulse; cmd_ready=1 afterwards.
- src=0x00000002 -> no m_valid ever asserted; err=1, err_addr=0x2; done pulse. Then words=0 with aligned addresses -> done pulse, err=0.
- TIMEOUT_CYCLES=16, responder never asserts ready -> err=1 after 16 valid cycles; m_valid drops; done pulse.
- Assert rst for 1 cycle mid-write of a 10-word copy -> m_valid=0 and busy=0 immediately (asynchronous); next command completes normally.
